// File: rtl/exu_alu_pkg.sv
// Shared opcode encoding and elaboration helpers for the pipelined execute ALU.
// INT_ASSERT and REG_ADDR_WIDTH normally come from the project defines; these fallbacks keep the slice self-contained.
`ifndef INT_ASSERT
`define INT_ASSERT 1'b1
`endif
`ifndef REG_ADDR_WIDTH
`define REG_ADDR_WIDTH 5
`endif

package exu_alu_pkg;

    localparam int ALU_OP_W = 22;

    localparam int ALU_OP_ADD   = 0;
    localparam int ALU_OP_SUB   = 1;
    localparam int ALU_OP_SLL   = 2;
    localparam int ALU_OP_SLT   = 3;
    localparam int ALU_OP_SLTU  = 4;
    localparam int ALU_OP_XOR   = 5;
    localparam int ALU_OP_SRL   = 6;
    localparam int ALU_OP_SRA   = 7;
    localparam int ALU_OP_OR    = 8;
    localparam int ALU_OP_AND   = 9;
    localparam int ALU_OP_LUI   = 10;
    localparam int ALU_OP_AUIPC = 11;
    localparam int ALU_OP_JUMP  = 12;
    localparam int ALU_OP_MIN   = 13;
    localparam int ALU_OP_MAX   = 14;
    localparam int ALU_OP_MINU  = 15;
    localparam int ALU_OP_MAXU  = 16;
    localparam int ALU_OP_ROL   = 17;
    localparam int ALU_OP_ROR   = 18;
    localparam int ALU_OP_ANDN  = 19;
    localparam int ALU_OP_ORN   = 20;
    localparam int ALU_OP_XNOR  = 21;

    // Bits at or above this index belong to the Zbb extension.
    localparam int ALU_BASE_OPS = 13;

    // Highest priority first; the first set bit in this order selects the operation.
    localparam int ALU_PRIO [ALU_OP_W] = '{
        ALU_OP_XOR, ALU_OP_OR, ALU_OP_AND, ALU_OP_ADD, ALU_OP_SUB, ALU_OP_SLL,
        ALU_OP_SRL, ALU_OP_SRA, ALU_OP_SLT, ALU_OP_SLTU, ALU_OP_LUI, ALU_OP_AUIPC,
        ALU_OP_JUMP, ALU_OP_MIN, ALU_OP_MAX, ALU_OP_MINU, ALU_OP_MAXU, ALU_OP_ROL,
        ALU_OP_ROR, ALU_OP_ANDN, ALU_OP_ORN, ALU_OP_XNOR
    };

    function automatic bit xlen_legal(input int xlen);
        return (xlen == 32) || (xlen == 64);
    endfunction

endpackage

// File: rtl/exu_alu_pipe_if.sv
// Dispatch-to-ALU request channel and ALU-to-writeback result channel.
interface exu_alu_pipe_if #(
    parameter int XLEN = 32,
    parameter int RD_W = `REG_ADDR_WIDTH
);
    import exu_alu_pkg::*;

    logic                in_valid_i;
    logic                in_ready_o;
    logic [XLEN-1:0]     op1_i;
    logic [XLEN-1:0]     op2_i;
    logic [ALU_OP_W-1:0] op_i;
    logic [RD_W-1:0]     rd_i;
    logic                out_valid_o;
    logic                out_ready_i;
    logic [XLEN-1:0]     result_o;
    logic                reg_we_o;
    logic [RD_W-1:0]     reg_waddr_o;

    modport master (
        output in_valid_i, op1_i, op2_i, op_i, rd_i, out_ready_i,
        input  in_ready_o, out_valid_o, result_o, reg_we_o, reg_waddr_o
    );

    modport slave (
        input  in_valid_i, op1_i, op2_i, op_i, rd_i, out_ready_i,
        output in_ready_o, out_valid_o, result_o, reg_we_o, reg_waddr_o
    );
endinterface

// File: rtl/exu_alu_dp.sv
// Combinational ALU datapath: priority-selects one operation from a one-hot-ish opcode vector.
module exu_alu_dp
    import exu_alu_pkg::*;
#(
    parameter int XLEN   = 32,
    parameter int ZBB_EN = 0
) (
    input  logic [XLEN-1:0]     i_op1,
    input  logic [XLEN-1:0]     i_op2,
    input  logic [ALU_OP_W-1:0] i_op,
    output logic [XLEN-1:0]     o_result,
    output logic                o_any_op
);
    localparam int SHW = $clog2(XLEN);

    logic [ALU_OP_W-1:0] w_op_eff;
    logic [SHW-1:0]      w_sh;
    logic [2*XLEN-1:0]   w_rot;
    logic [2*XLEN-1:0]   w_rol_full;
    logic [2*XLEN-1:0]   w_ror_full;
    logic                w_lt_s;
    logic                w_lt_u;
    int                  w_sel;

    // Zbb bits are simply invisible when the extension is disabled.
    for (genvar gi = 0; gi < ALU_OP_W; gi++) begin : g_mask
        if ((gi < ALU_BASE_OPS) || (ZBB_EN != 0)) begin : g_on
            assign w_op_eff[gi] = i_op[gi];
        end else begin : g_off
            assign w_op_eff[gi] = 1'b0;
        end
    end

    assign w_sh       = i_op2[SHW-1:0];
    assign w_rot      = {i_op1, i_op1};
    assign w_rol_full = w_rot << w_sh;
    assign w_ror_full = w_rot >> w_sh;
    assign w_lt_s     = $signed(i_op1) < $signed(i_op2);
    assign w_lt_u     = i_op1 < i_op2;
    assign o_any_op   = |w_op_eff;

    always_comb begin
        w_sel = 0;
        for (int k = ALU_OP_W - 1; k >= 0; k--) begin
            if (w_op_eff[ALU_PRIO[k]]) w_sel = ALU_PRIO[k];
        end
    end

    always_comb begin
        o_result = '0;
        if (o_any_op) begin
            case (w_sel)
                ALU_OP_ADD, ALU_OP_LUI, ALU_OP_AUIPC, ALU_OP_JUMP:
                              o_result = i_op1 + i_op2;
                ALU_OP_SUB:   o_result = i_op1 - i_op2;
                ALU_OP_SLL:   o_result = i_op1 << w_sh;
                ALU_OP_SLT:   o_result = {{(XLEN-1){1'b0}}, w_lt_s};
                ALU_OP_SLTU:  o_result = {{(XLEN-1){1'b0}}, w_lt_u};
                ALU_OP_XOR:   o_result = i_op1 ^ i_op2;
                ALU_OP_SRL:   o_result = i_op1 >> w_sh;
                ALU_OP_SRA:   o_result = $signed(i_op1) >>> w_sh;
                ALU_OP_OR:    o_result = i_op1 | i_op2;
                ALU_OP_AND:   o_result = i_op1 & i_op2;
                ALU_OP_MIN:   o_result = w_lt_s ? i_op1 : i_op2;
                ALU_OP_MAX:   o_result = w_lt_s ? i_op2 : i_op1;
                ALU_OP_MINU:  o_result = w_lt_u ? i_op1 : i_op2;
                ALU_OP_MAXU:  o_result = w_lt_u ? i_op2 : i_op1;
                ALU_OP_ROL:   o_result = w_rol_full[2*XLEN-1:XLEN];
                ALU_OP_ROR:   o_result = w_ror_full[XLEN-1:0];
                ALU_OP_ANDN:  o_result = i_op1 & ~i_op2;
                ALU_OP_ORN:   o_result = i_op1 | ~i_op2;
                ALU_OP_XNOR:  o_result = ~(i_op1 ^ i_op2);
                default:      o_result = '0;
            endcase
        end
    end
endmodule

// File: rtl/exu_alu_pipe.sv
// Pipelined execute ALU: valid/ready in, registered result out, 1 or 2 stages, flush on interrupt.
module exu_alu_pipe
    import exu_alu_pkg::*;
#(
    parameter int XLEN        = 32,
    parameter int PIPE_STAGES = 1,
    parameter int ZBB_EN      = 0,
    parameter int RD_W        = `REG_ADDR_WIDTH
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           int_assert_i,
    exu_alu_pipe_if.slave  bus
);
    if (!xlen_legal(XLEN)) begin : g_bad_xlen
        $error("exu_alu_pipe: XLEN must be 32 or 64");
    end
    if (PIPE_STAGES != 1 && PIPE_STAGES != 2) begin : g_bad_stages
        $error("exu_alu_pipe: PIPE_STAGES must be 1 or 2");
    end

    logic                w_flush;
    logic                w_in_ready;
    logic                w_accept;
    logic                w_out_adv;
    logic                w_dp_valid;
    logic [XLEN-1:0]     w_dp_op1;
    logic [XLEN-1:0]     w_dp_op2;
    logic [ALU_OP_W-1:0] w_dp_op;
    logic [RD_W-1:0]     w_dp_rd;
    logic [XLEN-1:0]     w_dp_result;
    logic                w_dp_any;

    logic                r_out_valid;
    logic [XLEN-1:0]     r_result;
    logic                r_any;
    logic [RD_W-1:0]     r_waddr;

    assign w_flush   = (int_assert_i == `INT_ASSERT);
    assign w_out_adv = !r_out_valid || bus.out_ready_i;
    assign w_accept  = bus.in_valid_i && w_in_ready;

    if (PIPE_STAGES == 1) begin : g_one
        assign w_in_ready = w_out_adv && !w_flush;
        assign w_dp_valid = w_accept;
        assign w_dp_op1   = bus.op1_i;
        assign w_dp_op2   = bus.op2_i;
        assign w_dp_op    = bus.op_i;
        assign w_dp_rd    = bus.rd_i;
    end else begin : g_two
        logic                r_s1_valid;
        logic [XLEN-1:0]     r_s1_op1;
        logic [XLEN-1:0]     r_s1_op2;
        logic [ALU_OP_W-1:0] r_s1_op;
        logic [RD_W-1:0]     r_s1_rd;
        logic                w_s1_load;

        assign w_s1_load  = !r_s1_valid || w_out_adv;
        assign w_in_ready = w_s1_load && !w_flush;
        assign w_dp_valid = r_s1_valid;
        assign w_dp_op1   = r_s1_op1;
        assign w_dp_op2   = r_s1_op2;
        assign w_dp_op    = r_s1_op;
        assign w_dp_rd    = r_s1_rd;

        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                r_s1_valid <= 1'b0;
                r_s1_op1   <= '0;
                r_s1_op2   <= '0;
                r_s1_op    <= '0;
                r_s1_rd    <= '0;
            end else if (w_flush) begin
                r_s1_valid <= 1'b0;
            end else if (w_s1_load) begin
                r_s1_valid <= w_accept;
                if (w_accept) begin
                    r_s1_op1 <= bus.op1_i;
                    r_s1_op2 <= bus.op2_i;
                    r_s1_op  <= bus.op_i;
                    r_s1_rd  <= bus.rd_i;
                end
            end
        end
    end

    exu_alu_dp #(
        .XLEN   (XLEN),
        .ZBB_EN (ZBB_EN)
    ) u_dp (
        .i_op1    (w_dp_op1),
        .i_op2    (w_dp_op2),
        .i_op     (w_dp_op),
        .o_result (w_dp_result),
        .o_any_op (w_dp_any)
    );

    // Output stage only moves when empty or drained, so a stalled result stays frozen.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_out_valid <= 1'b0;
            r_result    <= '0;
            r_any       <= 1'b0;
            r_waddr     <= '0;
        end else if (w_flush) begin
            r_out_valid <= 1'b0;
        end else if (w_out_adv) begin
            r_out_valid <= w_dp_valid;
            if (w_dp_valid) begin
                r_result <= w_dp_result;
                r_any    <= w_dp_any;
                r_waddr  <= w_dp_rd;
            end
        end
    end

    assign bus.in_ready_o  = w_in_ready;
    assign bus.out_valid_o = r_out_valid;
    assign bus.result_o    = r_result;
    assign bus.reg_we_o    = r_out_valid && r_any;
    assign bus.reg_waddr_o = r_out_valid ? r_waddr : '0;
endmodule

// File: tb/tb_exu_alu_pipe.sv
// Directed bench for exu_alu_pipe: vector table on 1-stage 32/64-bit Zbb cores, hand sequences on a 2-stage base core.
`ifndef INT_ASSERT
`define INT_ASSERT 1'b1
`endif

module tb_exu_alu_pipe;
    import exu_alu_pkg::*;

    localparam logic INT_IDLE = ~`INT_ASSERT;

    typedef struct {
        logic        sel64;
        logic [21:0] op;
        logic [63:0] op1;
        logic [63:0] op2;
        logic [4:0]  rd;
        logic [63:0] res;
        logic        we;
    } vec_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        int_idle;
    logic        int_b;
    logic        d_valid;
    logic [63:0] d_op1, d_op2;
    logic [21:0] d_op;
    logic [4:0]  d_rd;
    logic        b_valid, b_ready;
    logic [31:0] b_op1, b_op2;
    logic [21:0] b_op;
    logic [4:0]  b_rd;

    int n_checks = 0;
    int n_err    = 0;

    exu_alu_pipe_if #(.XLEN(32), .RD_W(5)) if_a ();
    exu_alu_pipe_if #(.XLEN(32), .RD_W(5)) if_b ();
    exu_alu_pipe_if #(.XLEN(64), .RD_W(5)) if_c ();

    assign if_a.in_valid_i  = d_valid;
    assign if_a.op1_i       = d_op1[31:0];
    assign if_a.op2_i       = d_op2[31:0];
    assign if_a.op_i        = d_op;
    assign if_a.rd_i        = d_rd;
    assign if_a.out_ready_i = 1'b1;

    assign if_c.in_valid_i  = d_valid;
    assign if_c.op1_i       = d_op1;
    assign if_c.op2_i       = d_op2;
    assign if_c.op_i        = d_op;
    assign if_c.rd_i        = d_rd;
    assign if_c.out_ready_i = 1'b1;

    assign if_b.in_valid_i  = b_valid;
    assign if_b.op1_i       = b_op1;
    assign if_b.op2_i       = b_op2;
    assign if_b.op_i        = b_op;
    assign if_b.rd_i        = b_rd;
    assign if_b.out_ready_i = b_ready;

    exu_alu_pipe #(.XLEN(32), .PIPE_STAGES(1), .ZBB_EN(1), .RD_W(5)) u_a (
        .clk(clk), .rst(rst), .int_assert_i(int_idle), .bus(if_a));
    exu_alu_pipe #(.XLEN(32), .PIPE_STAGES(2), .ZBB_EN(0), .RD_W(5)) u_b (
        .clk(clk), .rst(rst), .int_assert_i(int_b), .bus(if_b));
    exu_alu_pipe #(.XLEN(64), .PIPE_STAGES(1), .ZBB_EN(1), .RD_W(5)) u_c (
        .clk(clk), .rst(rst), .int_assert_i(int_idle), .bus(if_c));

    function automatic logic [21:0] ob(input int idx);
        logic [21:0] one;
        one = 22'd1;
        return one << idx;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end else begin
            $display("ok   %s = 0x%0h", name, act);
        end
    endtask

    vec_t vecs[$];

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int k, got, cyc;
        logic acc;

        vecs.push_back('{1'b0, ob(ALU_OP_ADD),   64'h7FFFFFFF, 64'd1,        5'd5,  64'h80000000, 1'b1});
        vecs.push_back('{1'b0, ob(ALU_OP_SUB),   64'd5,        64'd7,        5'd1,  64'hFFFFFFFE, 1'b1});
        vecs.push_back('{1'b0, ob(ALU_OP_SLL),   64'd1,        64'h23,       5'd2,  64'h8,        1'b1});
        vecs.push_back('{1'b0, ob(ALU_OP_SLT),   64'hFFFFFFFF, 64'd0,        5'd3,  64'd1,        1'b1});
        vecs.push_back('{1'b0, ob(ALU_OP_SLTU),  64'hFFFFFFFF, 64'd0,        5'd4,  64'd0,        1'b1});
        vecs.push_back('{1'b0, ob(ALU_OP_XOR),   64'hF0F0,     64'hFF00,     5'd6,  64'h0FF0,     1'b1});
        vecs.push_back('{1'b0, ob(ALU_OP_SRL),   64'h80000000, 64'd4,        5'd7,  64'h08000000, 1'b1});
        vecs.push_back('{1'b0, ob(ALU_OP_SRA),   64'h80000010, 64'd4,        5'd8,  64'hF8000001, 1'b1});
        vecs.push_back('{1'b0, ob(ALU_OP_OR),    64'h0F,       64'hF0,       5'd9,  64'hFF,       1'b1});
        vecs.push_back('{1'b0, ob(ALU_OP_AND),   64'h0F,       64'h3C,       5'd10, 64'h0C,       1'b1});
        vecs.push_back('{1'b0, ob(ALU_OP_LUI),   64'd0,        64'h12345000, 5'd11, 64'h12345000, 1'b1});
        vecs.push_back('{1'b0, ob(ALU_OP_AUIPC), 64'h1000,     64'h2000,     5'd12, 64'h3000,     1'b1});
        vecs.push_back('{1'b0, ob(ALU_OP_JUMP),  64'hFFFFFFFF, 64'd2,        5'd13, 64'd1,        1'b1});
        vecs.push_back('{1'b0, ob(ALU_OP_MIN),   64'hFFFFFFFF, 64'd5,        5'd14, 64'hFFFFFFFF, 1'b1});
        vecs.push_back('{1'b0, ob(ALU_OP_MAX),   64'hFFFFFFFF, 64'd5,        5'd15, 64'd5,        1'b1});
        vecs.push_back('{1'b0, ob(ALU_OP_MINU),  64'd3,        64'hFFFFFFFF, 5'd16, 64'd3,        1'b1});
        vecs.push_back('{1'b0, ob(ALU_OP_MAXU),  64'd3,        64'hFFFFFFFF, 5'd17, 64'hFFFFFFFF, 1'b1});
        vecs.push_back('{1'b0, ob(ALU_OP_ROL),   64'h80000001, 64'd1,        5'd18, 64'h3,        1'b1});
        vecs.push_back('{1'b0, ob(ALU_OP_ROR),   64'h80000001, 64'd1,        5'd19, 64'hC0000000, 1'b1});
        vecs.push_back('{1'b0, ob(ALU_OP_ANDN),  64'hFF,       64'h0F,       5'd20, 64'hF0,       1'b1});
        vecs.push_back('{1'b0, ob(ALU_OP_ORN),   64'h0,        64'hFFFF0000, 5'd21, 64'h0000FFFF, 1'b1});
        vecs.push_back('{1'b0, ob(ALU_OP_XNOR),  64'hFFFF0000, 64'hFF00FF00, 5'd22, 64'hFF0000FF, 1'b1});
        vecs.push_back('{1'b0, ob(ALU_OP_XOR) | ob(ALU_OP_ADD), 64'd6, 64'd3, 5'd23, 64'd5, 1'b1});
        vecs.push_back('{1'b0, ob(ALU_OP_MIN) | ob(ALU_OP_ADD), 64'hFFFFFFFF, 64'd5, 5'd24, 64'd4, 1'b1});
        vecs.push_back('{1'b0, ob(ALU_OP_SRL) | ob(ALU_OP_SLL), 64'd1, 64'd4, 5'd25, 64'd16, 1'b1});
        vecs.push_back('{1'b0, ob(ALU_OP_SLTU) | ob(ALU_OP_SLT), 64'hFFFFFFFF, 64'd0, 5'd26, 64'd1, 1'b1});
        vecs.push_back('{1'b0, 22'd0,            64'd9,        64'd9,        5'd27, 64'd0,        1'b0});
        vecs.push_back('{1'b0, ob(ALU_OP_ADD),   64'd1,        64'd1,        5'd0,  64'd2,        1'b1});
        vecs.push_back('{1'b0, ob(ALU_OP_ADD),   64'd4,        64'd4,        5'd31, 64'd8,        1'b1});
        vecs.push_back('{1'b1, ob(ALU_OP_SLL),   64'd1,        64'd63,       5'd1,  64'h8000000000000000, 1'b1});
        vecs.push_back('{1'b1, ob(ALU_OP_ROR),   64'd1,        64'd1,        5'd2,  64'h8000000000000000, 1'b1});
        vecs.push_back('{1'b1, ob(ALU_OP_SRA),   64'h8000000000000000, 64'd63, 5'd3, 64'hFFFFFFFFFFFFFFFF, 1'b1});
        vecs.push_back('{1'b1, ob(ALU_OP_ADD),   64'hFFFFFFFFFFFFFFFF, 64'd1,  5'd4, 64'd0, 1'b1});
        vecs.push_back('{1'b1, ob(ALU_OP_SLL),   64'd1,        64'd65,       5'd5,  64'd2,        1'b1});
        vecs.push_back('{1'b1, ob(ALU_OP_ROL),   64'h8000000000000001, 64'd4, 5'd6, 64'h18, 1'b1});

        rst = 1'b0; int_idle = INT_IDLE; int_b = INT_IDLE;
        d_valid = 1'b0; d_op1 = '0; d_op2 = '0; d_op = '0; d_rd = '0;
        b_valid = 1'b0; b_ready = 1'b1; b_op1 = '0; b_op2 = '0; b_op = '0; b_rd = '0;

        repeat (3) @(negedge clk);
        chk("reset a out_valid", 64'(if_a.out_valid_o), 64'd0);
        chk("reset a result",    64'(if_a.result_o), 64'd0);
        rst = 1'b1;
        @(negedge clk);
        chk("post-reset a in_ready", 64'(if_a.in_ready_o), 64'd1);
        chk("post-reset a we",       64'(if_a.reg_we_o), 64'd0);
        chk("post-reset a waddr",    64'(if_a.reg_waddr_o), 64'd0);
        chk("post-reset b in_ready", 64'(if_b.in_ready_o), 64'd1);
        chk("post-reset b out_valid", 64'(if_b.out_valid_o), 64'd0);

        foreach (vecs[i]) begin
            @(negedge clk);
            d_valid = 1'b1; d_op = vecs[i].op; d_op1 = vecs[i].op1;
            d_op2 = vecs[i].op2; d_rd = vecs[i].rd;
            @(negedge clk);
            d_valid = 1'b0;
            if (!vecs[i].sel64) begin
                chk($sformatf("vec%0d valid", i),  64'(if_a.out_valid_o), 64'd1);
                chk($sformatf("vec%0d result", i), 64'(if_a.result_o), vecs[i].res);
                chk($sformatf("vec%0d we", i),     64'(if_a.reg_we_o), 64'(vecs[i].we));
                chk($sformatf("vec%0d waddr", i),  64'(if_a.reg_waddr_o), 64'(vecs[i].rd));
            end else begin
                chk($sformatf("vec%0d x64 valid", i),  64'(if_c.out_valid_o), 64'd1);
                chk($sformatf("vec%0d x64 result", i), if_c.result_o, vecs[i].res);
                chk($sformatf("vec%0d x64 we", i),     64'(if_c.reg_we_o), 64'(vecs[i].we));
            end
        end
        @(negedge clk);
        chk("idle a out_valid", 64'(if_a.out_valid_o), 64'd0);
        chk("idle a waddr",     64'(if_a.reg_waddr_o), 64'd0);

        // Zbb bit alone on a core without the extension, checking 2-cycle latency.
        b_valid = 1'b1; b_op = ob(ALU_OP_ROL); b_op1 = 32'h80000001; b_op2 = 32'd1; b_rd = 5'd4;
        @(negedge clk);
        b_valid = 1'b0;
        chk("b rol latency gap", 64'(if_b.out_valid_o), 64'd0);
        @(negedge clk);
        chk("b rol valid",  64'(if_b.out_valid_o), 64'd1);
        chk("b rol result", 64'(if_b.result_o), 64'd0);
        chk("b rol we",     64'(if_b.reg_we_o), 64'd0);
        chk("b rol waddr",  64'(if_b.reg_waddr_o), 64'd4);

        // Back-pressure: out_ready low for the first 3 cycles of a 4-op stream.
        k = 0; got = 0; cyc = 0;
        while (got < 4 && cyc < 30) begin
            @(negedge clk);
            b_ready = (cyc >= 3);
            b_valid = (k < 4);
            b_op = ob(ALU_OP_ADD); b_op1 = 32'(k + 1); b_op2 = 32'd0; b_rd = 5'(k + 1);
            #1;
            if (cyc == 2) chk("bp in_ready when full", 64'(if_b.in_ready_o), 64'd0);
            if (if_b.out_valid_o) begin
                chk($sformatf("bp out%0d result", got + 1), 64'(if_b.result_o), 64'(got + 1));
                chk($sformatf("bp out%0d we", got + 1), 64'(if_b.reg_we_o), 64'd1);
                chk($sformatf("bp out%0d waddr", got + 1), 64'(if_b.reg_waddr_o), 64'(got + 1));
                if (b_ready) got++;
            end
            acc = b_valid && if_b.in_ready_o;
            @(posedge clk);
            if (acc) k++;
            cyc++;
        end
        chk("bp results drained", 64'(got), 64'd4);
        @(negedge clk);
        b_valid = 1'b0;
        @(negedge clk);
        chk("bp no duplicate", 64'(if_b.out_valid_o), 64'd0);

        // Flush with two ops in flight and a third offered during the flush cycle.
        b_ready = 1'b1;
        b_valid = 1'b1; b_op = ob(ALU_OP_ADD); b_op1 = 32'd10; b_op2 = 32'd0; b_rd = 5'd1;
        @(negedge clk);
        b_op1 = 32'd20; b_rd = 5'd2;
        @(negedge clk);
        int_b = `INT_ASSERT; b_op1 = 32'd30; b_rd = 5'd3;
        #1;
        chk("flush in_ready", 64'(if_b.in_ready_o), 64'd0);
        @(negedge clk);
        int_b = INT_IDLE; b_valid = 1'b0;
        chk("flush out_valid", 64'(if_b.out_valid_o), 64'd0);
        chk("flush we",        64'(if_b.reg_we_o), 64'd0);
        chk("flush waddr",     64'(if_b.reg_waddr_o), 64'd0);
        @(negedge clk);
        chk("flush dropped input", 64'(if_b.out_valid_o), 64'd0);
        b_valid = 1'b1; b_op1 = 32'd7; b_rd = 5'd9;
        @(negedge clk);
        b_valid = 1'b0;
        chk("post-flush gap", 64'(if_b.out_valid_o), 64'd0);
        @(negedge clk);
        chk("post-flush valid",  64'(if_b.out_valid_o), 64'd1);
        chk("post-flush result", 64'(if_b.result_o), 64'd7);
        chk("post-flush we",     64'(if_b.reg_we_o), 64'd1);
        chk("post-flush waddr",  64'(if_b.reg_waddr_o), 64'd9);

        // Asynchronous reset while a result sits in the output stage.
        @(negedge clk);
        b_ready = 1'b0; b_valid = 1'b1; b_op1 = 32'd3; b_rd = 5'd3;
        @(negedge clk);
        b_valid = 1'b0;
        @(posedge clk);
        #2;
        rst = 1'b0;
        #1;
        chk("midreset out_valid", 64'(if_b.out_valid_o), 64'd0);
        chk("midreset result",    64'(if_b.result_o), 64'd0);
        chk("midreset waddr",     64'(if_b.reg_waddr_o), 64'd0);
        @(negedge clk);
        rst = 1'b1; b_ready = 1'b1;
        @(negedge clk);
        chk("after midreset out_valid", 64'(if_b.out_valid_o), 64'd0);
        chk("after midreset in_ready",  64'(if_b.in_ready_o), 64'd1);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end
endmodule

// File: doc/exu_alu_pipe.md
Name: exu_alu_pipe

Overview:
- Parametrised, pipelined successor to the single-cycle execute ALU.
- Accepts one operation per cycle over a valid/ready handshake and returns a registered result with its writeback address and enable.
- Configurable datapath width and pipeline depth (1 or 2 stages), plus an optional Zbb-style extension (min/max, rotate, andn/orn/xnor).
- Sits between the dispatch stage and the writeback arbiter. Interrupt assertion flushes everything in flight.

Parameters:
- XLEN, 32, datapath width in bits; legal values are 32 and 64.
- PIPE_STAGES, 1, register stages from accept to result; legal values are 1 and 2.
- ZBB_EN, 0, set to 1 to enable opcode bits 13..21; when 0 those bits are ignored.
- RD_W, 5, width of the destination register address.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-low reset.
- in_valid_i  input  1  request valid.
- in_ready_o  output  1  block can accept the request this cycle.
- op1_i  input  XLEN  operand 1.
- op2_i  input  XLEN  operand 2 (register or immediate, already selected).
- op_i  input  22  one-hot opcode vector; bit order is defined in exu_alu_pkg.
- rd_i  input  RD_W  destination register.
- int_assert_i  input  1  flush; active at the `INT_ASSERT level.
- out_valid_o  output  1  result valid.
- out_ready_i  input  1  consumer accepts the result.
- result_o  output  XLEN  result.
- reg_we_o  output  1  writeback enable.
- reg_waddr_o  output  RD_W  writeback address.

Behaviour:
- Opcode bit order (0..21): add, sub, sll, slt, sltu, xor, srl, sra, or, and, lui, auipc, jump, min, max, minu, maxu, rol, ror, andn, orn, xnor.
- Selection priority when more than one bit is set: xor, or, and, add, sub, sll, srl, sra, slt, sltu, lui, auipc, jump, then the Zbb bits in index order. The first set bit wins.
- Arithmetic rules:
  - add, lui, auipc and jump compute op1+op2 modulo 2^XLEN.
  - sub computes op1-op2.
  - Shift and rotate amounts are op2[$clog2(XLEN)-1:0].
  - sra fills vacated bits with op1[XLEN-1].
  - slt/min/max compare signed; sltu/minu/maxu compare unsigned. slt/sltu produce 1 or 0 zero-extended to XLEN.
  - andn = op1&~op2, orn = op1|~op2, xnor = ~(op1^op2).
- Empty opcode (no effective bit set): result is 0 and reg_we is 0. Any effective bit set gives reg_we = 1, including rd = 0; the register file ignores writes to x0.
- Pipeline:
  - Each stage holds a valid bit plus a payload.
  - A stage loads when it is empty or its downstream stage advances that cycle.
  - in_ready_o = (stage-1 empty or stage-1 advancing) and the flush is not asserted.
  - Accept happens when in_valid_i and in_ready_o are both high.
- PIPE_STAGES=1: the datapath is computed combinationally from the inputs and registered at accept. out_valid_o rises on the next edge, giving latency 1.
- PIPE_STAGES=2: stage 1 registers the operands, opcode and rd; stage 2 registers the computed result. Latency is 2.
- Throughput is 1 op/cycle with out_ready_i held high. When out_ready_i is low, the result, we and waddr hold stable and back-pressure propagates upstream without bubbles being lost.
- The output stage is never modified while out_valid_o=1 and out_ready_i=0.
- Flush: with int_assert_i at `INT_ASSERT, in_ready_o=0 combinationally and all stage valid bits clear on the next edge. The input in that cycle is dropped. Payload registers may retain stale values but out_valid_o, reg_we_o and reg_waddr_o must read 0.
- reg_we_o and reg_waddr_o are gated to 0 whenever out_valid_o=0.
- Reset (rst low, asynchronous): all valid bits are 0, and out_valid_o, result_o, reg_we_o and reg_waddr_o are 0. in_ready_o is 1 after release, provided the flush is not asserted.
- A reset asserted mid-stream discards all in-flight results; no partial result is ever emitted.

Decomposition:
- exu_alu_pkg holds:
  - opcode index localparams (ALU_OP_ADD=0 … ALU_OP_XNOR=21);
  - ALU_OP_W=22;
  - the legal-XLEN check.
- `INT_ASSERT and `REG_ADDR_WIDTH come from defines.v.
- One combinational sub-module, exu_alu_dp, takes op1, op2, op and ZBB_EN and returns the result and an any-op flag.
- The top module instantiates exu_alu_dp once and places it according to PIPE_STAGES (before the single register, or between the two registers).

Test Plan:
- Reset and basic add: with PIPE_STAGES=1 and XLEN=32, release rst and drive add with op1=0x7FFFFFFF, op2=1, rd=5 → one cycle later out_valid=1, result=0x80000000, we=1, waddr=5.
- Signed and unsigned ops: sra with op1=0x80000010, op2=4 → 0xF8000001. slt with op1=0xFFFFFFFF, op2=0 → 1. sltu with the same operands → 0. With ZBB_EN=1, minu with op1=3, op2=0xFFFFFFFF → 3.
- Back-pressure (PIPE_STAGES=2): stream 4 adds with out_ready low for 3 cycles → in_ready drops once both stages are full, and the outputs remain in order 1,2,3,4 with no drop or duplicate.
- Flush mid-stream: with 2 ops in flight, assert int_assert_i for 1 cycle → next cycle out_valid=0 and we=0; the following op issues normally with latency 2.
- Priority and empty opcode: op_i with the xor and add bits set, op1=6, op2=3 → result 5. op_i=0 → result 0, we=0. With ZBB_EN=0, the rol bit alone → result 0, we=0.
- XLEN=64: sll with op1=1, op2=63 → 0x8000000000000000. ror with ZBB_EN=1, op1=1, op2=1 → 0x8000000000000000.
